// File: rtl/spi_master_unit_if.sv
// Host-side and SPI-side signal bundle for spi_master_unit.
// Carries the optional busy flag when SPI_MASTER_BUSY_EN is defined.
interface spi_master_unit_if #(
  parameter int DATA_W = 8
);
  logic              mlb;
  logic              start;
  logic [DATA_W-1:0] tdat;
  logic [1:0]        cdiv;
  logic              din;
  logic              ss;
  logic              sck;
  logic              dout;
  logic              done;
  logic [DATA_W-1:0] rdata;
`ifdef SPI_MASTER_BUSY_EN
  logic              busy;

  modport master (input mlb, start, tdat, cdiv, din,
                  output ss, sck, dout, done, rdata, busy);
  modport slave  (output mlb, start, tdat, cdiv, din,
                  input ss, sck, dout, done, rdata, busy);
`else
  modport master (input mlb, start, tdat, cdiv, din,
                  output ss, sck, dout, done, rdata);
  modport slave  (output mlb, start, tdat, cdiv, din,
                  input ss, sck, dout, done, rdata);
`endif
endinterface

// File: rtl/spi_master_unit.sv
// SPI mode-0 master: one DATA_W-bit word per transfer, sck half-period 2^(cdiv+1) clk.
// Optional busy output enabled by defining SPI_MASTER_BUSY_EN.
module spi_master_unit #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rstb,
  spi_master_unit_if.master bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] BITS_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] BITS_LAST = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_start_q;
  logic              w_req;
  logic [3:0]        r_div;
  logic [3:0]        w_half_m1;
  logic              w_tick;
  logic              w_last_fall;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic              r_mlb;
  logic [1:0]        r_cdiv;
  logic [CNT_W-1:0]  r_bits;
  logic              r_ss;
  logic              r_sck;
  logic              r_dout;
  logic              r_done;
  logic [DATA_W-1:0] r_rdata;

  assign w_req       = bus.start & ~r_start_q;
  assign w_tick      = (r_div == w_half_m1);
  assign w_last_fall = w_tick & r_sck & (r_bits == BITS_LAST);

  // Divider terminal count for the latched cdiv.
  always_comb begin
    w_half_m1 = 4'd1;
    case (r_cdiv)
      2'd0:    w_half_m1 = 4'd1;
      2'd1:    w_half_m1 = 4'd3;
      2'd2:    w_half_m1 = 4'd7;
      2'd3:    w_half_m1 = 4'd15;
      default: w_half_m1 = 4'd1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_next = SEND;
        end else begin
          w_next = IDLE;
        end
      end
      SEND: begin
        if (w_last_fall) begin
          w_next = FINISH;
        end else begin
          w_next = SEND;
        end
      end
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // ss, done and rdata are updated on the final sck fall so ss is low for
  // exactly 2*DATA_W*H cycles and FINISH presents the completed result.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      r_start_q <= 1'b0;
      r_div     <= 4'd0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_mlb     <= 1'b0;
      r_cdiv    <= 2'd0;
      r_bits    <= '0;
      r_ss      <= 1'b1;
      r_sck     <= 1'b0;
      r_dout    <= 1'b0;
      r_done    <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_start_q <= bus.start;
      r_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_tx   <= bus.tdat;
            r_mlb  <= bus.mlb;
            r_cdiv <= bus.cdiv;
            r_ss   <= 1'b0;
            r_dout <= bus.mlb ? bus.tdat[DATA_W-1] : bus.tdat[0];
            r_div  <= 4'd0;
            r_bits <= '0;
            r_sck  <= 1'b0;
            r_rx   <= '0;
          end
        end
        SEND: begin
          if (w_tick) begin
            r_div <= 4'd0;
            r_sck <= ~r_sck;
            if (!r_sck) begin
              r_rx   <= r_mlb ? {r_rx[DATA_W-2:0], bus.din} : {bus.din, r_rx[DATA_W-1:1]};
              r_bits <= r_bits + BITS_ONE;
            end else if (r_bits != BITS_LAST) begin
              if (r_mlb) begin
                r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
                r_dout <= r_tx[DATA_W-2];
              end else begin
                r_tx   <= {1'b0, r_tx[DATA_W-1:1]};
                r_dout <= r_tx[1];
              end
            end else begin
              r_ss    <= 1'b1;
              r_done  <= 1'b1;
              r_rdata <= r_rx;
            end
          end else begin
            r_div <= r_div + 4'd1;
          end
        end
        FINISH: begin
          r_ss <= 1'b1;
        end
        default: begin
          r_ss <= 1'b1;
        end
      endcase
    end
  end

`ifdef SPI_MASTER_BUSY_EN
  logic r_busy;

  // busy covers SEND and FINISH.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_next != IDLE);
    end
  end

  assign bus.busy = r_busy;
`endif

  assign bus.ss    = r_ss;
  assign bus.sck   = r_sck;
  assign bus.dout  = r_dout;
  assign bus.done  = r_done;
  assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_spi_master_unit.sv
// Scoreboard bench for spi_master_unit with a mode-0 slave model.
// Define SPI_MASTER_BUSY_EN to also check the busy output.
`timescale 1ns/1ps
module tb_spi_master_unit;
  localparam int DATA_W = 8;

  typedef struct {
    logic [7:0] rdata;
    logic [7:0] seq;
    int         period;
    int         sslen;
  } exp_t;

  logic clk = 1'b0;
  logic rstb;
  bit   clk_en = 1'b1;

  spi_master_unit_if #(.DATA_W(DATA_W)) u_if ();
  spi_master_unit #(.DATA_W(DATA_W)) u_dut (.clk(clk), .rstb(rstb), .bus(u_if));

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  logic [7:0] slave_word = 8'h00;
  logic [7:0] slave_last = 8'h00;

  // Monitor / slave state
  logic       p_ss = 1'b1, p_sck = 1'b0, p_done = 1'b0;
  int         ss_cnt = 0, cyc = 0, pulses = 0, busy_cnt = 0;
  logic [7:0] obs = 8'h00, s_sh = 8'h00, s_rx = 8'h00;
  logic       s_mlb = 1'b0;
  exp_t       e;

  initial begin
    forever begin
      #25;
      if (clk_en) clk = ~clk;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic issue(input logic [7:0] td, input logic m, input logic [1:0] cd,
                       input logic [7:0] sw, input logic [7:0] er, input logic [7:0] es,
                       input int h);
    exp_t x;
    x.rdata = er;
    x.seq = es;
    x.period = 2 * h;
    x.sslen = 16 * h;
    sb.push_back(x);
    u_if.tdat = td;
    u_if.mlb = m;
    u_if.cdiv = cd;
    slave_word = sw;
    u_if.start = 1'b1;
  endtask

  task automatic wait_done(input int max_cyc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("xfer_complete_pending", sb.size(), 0);
    if (sb.size() != 0) sb.delete();
  endtask

  task automatic monitor_step();
    if (rstb) begin
      ss_cnt = 0; cyc = 0; pulses = 0; busy_cnt = 0; obs = 8'h00; s_rx = 8'h00;
      p_ss = 1'b1; p_sck = 1'b0; p_done = 1'b0;
    end else begin
      if (!u_if.ss) ss_cnt++;
      cyc++;
`ifdef SPI_MASTER_BUSY_EN
      if (u_if.busy) busy_cnt++;
`endif
      if (!u_if.ss && p_ss) begin
        s_sh = slave_word;
        s_mlb = u_if.mlb;
        s_rx = 8'h00;
        obs = 8'h00;
        pulses = 0;
        u_if.din = s_mlb ? s_sh[7] : s_sh[0];
      end
      if (u_if.sck && !p_sck) begin
        if (pulses > 0 && sb.size() > 0) chk("sck_period", cyc, sb[0].period);
        cyc = 0;
        pulses++;
        obs = {obs[6:0], u_if.dout};
        s_rx = s_mlb ? {s_rx[6:0], u_if.dout} : {u_if.dout, s_rx[7:1]};
      end
      if (!u_if.sck && p_sck && !u_if.ss) begin
        if (s_mlb) begin
          s_sh = {s_sh[6:0], 1'b0};
          u_if.din = s_sh[7];
        end else begin
          s_sh = {1'b0, s_sh[7:1]};
          u_if.din = s_sh[0];
        end
      end
      if (u_if.ss && !p_ss) slave_last = s_rx;
      if (u_if.done) begin
        done_cnt++;
        chk("done_width_prev", p_done, 1'b0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual done=1 required no transfer pending");
        end else begin
          e = sb.pop_front();
          chk("rdata", u_if.rdata, e.rdata);
          chk("dout_seq", obs, e.seq);
          chk("sck_pulses", pulses, 8);
          chk("ss_low_cycles", ss_cnt, e.sslen);
`ifdef SPI_MASTER_BUSY_EN
          chk("busy_cycles", busy_cnt, e.sslen + 1);
`endif
        end
        ss_cnt = 0; busy_cnt = 0; pulses = 0; cyc = 0;
      end
      p_ss = u_if.ss;
      p_sck = u_if.sck;
      p_done = u_if.done;
    end
  endtask

  initial begin
    int n, r;
    logic ps;
    rstb = 1'b1;
    u_if.start = 1'b0;
    u_if.tdat = 8'h00;
    u_if.mlb = 1'b0;
    u_if.cdiv = 2'd0;
    u_if.din = 1'b0;
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    #100;
    chk("reset_ss", u_if.ss, 1'b1);
    chk("reset_sck", u_if.sck, 1'b0);
    chk("reset_done", u_if.done, 1'b0);
    chk("reset_rdata", u_if.rdata, 8'h00);
    chk("reset_dout", u_if.dout, 1'b0);
`ifdef SPI_MASTER_BUSY_EN
    chk("reset_busy", u_if.busy, 1'b0);
`endif
    @(negedge clk);
    rstb = 1'b0;
    repeat (3) @(negedge clk);

    // LSB first, cdiv 00
    issue(8'h7C, 1'b0, 2'd0, 8'hAA, 8'hAA, 8'h3E, 2);
    @(negedge clk);
    u_if.start = 1'b0;
    wait_done(100);
    repeat (3) @(negedge clk);

    // MSB first, cdiv 01, slave echoes the 0x7C it just received
    issue(8'h1C, 1'b1, 2'd1, slave_last, 8'h7C, 8'h1C, 4);
    @(negedge clk);
    u_if.start = 1'b0;
    wait_done(200);
    repeat (3) @(negedge clk);

    // Reset with the clock stopped
    clk_en = 1'b0;
    #40;
    rstb = 1'b1;
    #20;
    rstb = 1'b0;
    #1;
    chk("stopped_clk_rst_rdata", u_if.rdata, 8'h00);
    chk("stopped_clk_rst_ss", u_if.ss, 1'b1);
    chk("stopped_clk_rst_sck", u_if.sck, 1'b0);
    chk("stopped_clk_rst_done", u_if.done, 1'b0);
    clk_en = 1'b1;
    repeat (3) @(negedge clk);

    // start held high through the whole transfer
    issue(8'h96, 1'b0, 2'd0, 8'h5C, 8'h5C, 8'h69, 2);
    repeat (45) @(negedge clk);
    chk("held_start_done_count", done_cnt, 3);
    chk("held_start_pending", sb.size(), 0);
    u_if.start = 1'b0;
    repeat (2) @(negedge clk);
    issue(8'h3C, 1'b1, 2'd0, 8'hC3, 8'hC3, 8'h3C, 2);
    @(negedge clk);
    u_if.start = 1'b0;
    wait_done(100);
    repeat (3) @(negedge clk);

    // Back-to-back: second request in the first idle cycle after FINISH
    issue(8'hA5, 1'b1, 2'd0, 8'h0F, 8'h0F, 8'hA5, 2);
    @(negedge clk);
    u_if.start = 1'b0;
    n = 0;
    while (!u_if.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    issue(8'h01, 1'b0, 2'd0, 8'hF0, 8'hF0, 8'h80, 2);
    @(negedge clk);
    u_if.start = 1'b0;
    wait_done(100);
    chk("b2b_done_count", done_cnt, 6);
    repeat (3) @(negedge clk);

    // Inputs changed during SEND leave the frame unchanged
    issue(8'h5A, 1'b1, 2'd0, 8'h3C, 8'h3C, 8'h5A, 2);
    @(negedge clk);
    u_if.start = 1'b0;
    repeat (10) @(negedge clk);
    u_if.tdat = 8'hE3;
    u_if.cdiv = 2'd3;
    wait_done(100);
    repeat (3) @(negedge clk);
    issue(8'hE3, 1'b1, 2'd3, 8'h81, 8'h81, 8'hE3, 16);
    @(negedge clk);
    u_if.start = 1'b0;
    wait_done(400);
    repeat (3) @(negedge clk);

    // Abort after three sck pulses
    u_if.tdat = 8'hFF;
    u_if.mlb = 1'b0;
    u_if.cdiv = 2'd0;
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    n = 0;
    r = 0;
    ps = 1'b0;
    while (r < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (u_if.sck && !ps) r++;
      ps = u_if.sck;
    end
    chk("abort_pulses_seen", r, 3);
    #5;
    rstb = 1'b1;
    #1;
    chk("abort_ss", u_if.ss, 1'b1);
    chk("abort_sck", u_if.sck, 1'b0);
    chk("abort_rdata", u_if.rdata, 8'h00);
    chk("abort_done", u_if.done, 1'b0);
`ifdef SPI_MASTER_BUSY_EN
    chk("abort_busy", u_if.busy, 1'b0);
`endif
    @(negedge clk);
    rstb = 1'b0;
    repeat (60) @(negedge clk);
    chk("final_done_count", done_cnt, 8);
    chk("final_pending", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
